word_extract: RTL and testbench

- Inverse of the word-insertion stage in pkt_comm.
- Takes a finished candidate: WORD_MAX_LEN chars, zero-padded, char 0 in the LSBs.
- Splits it back into the inserted word and the compacted range-generator chars, using the word_pos/word_len that built it.
- Sits on the debug/verification path after candidate generation.
- Iterative, one char per clock, with a one-entry input latch and a one-entry output register, both handshaked.

---
 rtl/word_extract_pkg.sv | 41 ++++
 rtl/word_extract_if.sv | 29 ++
 rtl/word_extract_window.sv | 24 ++
 rtl/word_extract.sv | 187 ++++++++++++++++++
 tb/tb_word_extract.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/word_extract_pkg.sv
// Shared constants, FSM encoding and helpers for word_extract.
// Optional compare path is enabled by defining WORD_EXTRACT_CHECK_EN.
`ifndef WORD_EXTRACT_MSB_DEFINED
`define WORD_EXTRACT_MSB_DEFINED
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package word_extract_pkg;

  localparam int unsigned CHAR_BITS    = 7;
  localparam int unsigned RANGES_MAX   = 8;
  localparam int unsigned WORD_MAX_LEN = RANGES_MAX;
  localparam int unsigned WORD_LEN_MSB = `MSB(WORD_MAX_LEN);
  localparam int unsigned POS_BITS     = `MSB(WORD_MAX_LEN - 1) + 1;
  localparam int unsigned IDX_BITS     = POS_BITS;
  // Window sums are one bit wider than the length field so they never wrap.
  localparam int unsigned SUM_BITS     = WORD_LEN_MSB + 2;
  localparam int unsigned RC_BITS      = $clog2(RANGES_MAX + 1);
  localparam int unsigned DATA_BITS    = WORD_MAX_LEN * CHAR_BITS;
  localparam int unsigned RANGE_BITS   = RANGES_MAX * CHAR_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCmp,
    StDone
  } state_e;

  typedef logic [CHAR_BITS-1:0] char_t;

  // Bit mask covering the first len chars of a candidate.
  function automatic logic [DATA_BITS-1:0] char_mask(input logic [WORD_LEN_MSB:0] len);
    logic [DATA_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(WORD_MAX_LEN); i++) begin
      if (i < int'(len)) m[i*CHAR_BITS +: CHAR_BITS] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/word_extract_if.sv
// Handshake and data bundle between a word_extract instance and its driver.
interface word_extract_if;
  import word_extract_pkg::*;

  logic [DATA_BITS-1:0]    din;
  logic [WORD_LEN_MSB:0]   word_len;
  logic [POS_BITS-1:0]     word_pos;
  logic [DATA_BITS-1:0]    word_ref;
  logic                    wr_en;
  logic                    full;
  logic [RANGE_BITS-1:0]   range_out;
  logic [WORD_LEN_MSB:0]   range_len;
  logic [DATA_BITS-1:0]    word_out;
  logic                    err;
  logic                    mismatch;
  logic                    rd_en;
  logic                    empty;

  modport slave (
    input  din, word_len, word_pos, word_ref, wr_en, rd_en,
    output full, range_out, range_len, word_out, err, mismatch, empty
  );

  modport master (
    output din, word_len, word_pos, word_ref, wr_en, rd_en,
    input  full, range_out, range_len, word_out, err, mismatch, empty
  );

endinterface

// File: rtl/word_extract_window.sv
// Combinational window decision: is char idx inside [pos, pos+len), and where in the word.
module word_extract_window
  import word_extract_pkg::*;
(
  input  logic [IDX_BITS-1:0]   idx_i,
  input  logic [POS_BITS-1:0]   pos_i,
  input  logic [WORD_LEN_MSB:0] len_i,
  output logic                  in_win_o,
  output logic [IDX_BITS-1:0]   word_idx_o
);

  logic [SUM_BITS-1:0] idx_ext;
  logic [SUM_BITS-1:0] pos_ext;
  logic [SUM_BITS-1:0] end_ext;

  always_comb begin
    idx_ext    = SUM_BITS'(idx_i);
    pos_ext    = SUM_BITS'(pos_i);
    end_ext    = pos_ext + SUM_BITS'(len_i);
    in_win_o   = (idx_ext >= pos_ext) && (idx_ext < end_ext);
    word_idx_o = idx_i - pos_i;
  end

endmodule

// File: rtl/word_extract.sv
// Splits a finished candidate back into inserted word and compacted range chars.
// Define WORD_EXTRACT_CHECK_EN to add a registered compare of word_out against word_ref.
module word_extract
  import word_extract_pkg::*;
(
  input  logic           CLK,
  input  logic           reset,
  word_extract_if.slave  bus
);

  state_e                state_q, state_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_BITS-1:0]  din_q, din_d;
  logic [WORD_LEN_MSB:0] len_q, len_d;
  logic [POS_BITS-1:0]   pos_q, pos_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [RC_BITS-1:0]    rc_q, rc_d;
  logic [RANGE_BITS-1:0] range_out_q, range_out_d;
  logic [DATA_BITS-1:0]  word_out_q, word_out_d;
  logic [WORD_LEN_MSB:0] range_len_q, range_len_d;
  logic                  zero_seen_q, zero_seen_d;
  logic                  err_q, err_d;
`ifdef WORD_EXTRACT_CHECK_EN
  logic [DATA_BITS-1:0]  ref_q, ref_d;
  logic                  mismatch_q, mismatch_d;
`else
  logic                  unused_word_ref;
  assign unused_word_ref = ^bus.word_ref;
`endif

  logic                  accept;
  logic                  in_win;
  logic [IDX_BITS-1:0]   word_idx;
  char_t                 c;

  word_extract_window u_window (
    .idx_i      (idx_q),
    .pos_i      (pos_q),
    .len_i      (len_q),
    .in_win_o   (in_win),
    .word_idx_o (word_idx)
  );

  assign accept = bus.wr_en && !full_q;
  assign c      = din_q[int'(idx_q)*CHAR_BITS +: CHAR_BITS];

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    empty_d     = empty_q;
    din_d       = din_q;
    len_d       = len_q;
    pos_d       = pos_q;
    idx_d       = idx_q;
    rc_d        = rc_q;
    range_out_d = range_out_q;
    word_out_d  = word_out_q;
    range_len_d = range_len_q;
    zero_seen_d = zero_seen_q;
    err_d       = err_q;
`ifdef WORD_EXTRACT_CHECK_EN
    ref_d       = ref_q;
    mismatch_d  = mismatch_q;
`endif

    if (accept) begin
      din_d  = bus.din;
      len_d  = bus.word_len;
      pos_d  = bus.word_pos;
      full_d = 1'b1;
`ifdef WORD_EXTRACT_CHECK_EN
      ref_d  = bus.word_ref;
`endif
    end

    case (state_q)
      StIdle: begin
        if (full_q) begin
          state_d     = StScan;
          idx_d       = '0;
          rc_d        = '0;
          range_out_d = '0;
          word_out_d  = '0;
          range_len_d = '0;
          zero_seen_d = 1'b0;
          err_d       = 1'b0;
`ifdef WORD_EXTRACT_CHECK_EN
          mismatch_d  = 1'b0;
`endif
        end
      end
      StScan: begin
        if (in_win) begin
          word_out_d[int'(word_idx)*CHAR_BITS +: CHAR_BITS] = c;
        end else if (rc_q < RC_BITS'(RANGES_MAX)) begin
          // Chars beyond RANGES_MAX range slots are dropped.
          range_out_d[int'(rc_q)*CHAR_BITS +: CHAR_BITS] = c;
          rc_d = rc_q + 1'b1;
          if (!zero_seen_q) begin
            if (c == '0) zero_seen_d = 1'b1;
            else         range_len_d = range_len_q + 1'b1;
          end
        end
        if (idx_q == IDX_BITS'(WORD_MAX_LEN - 1)) begin
          err_d = (SUM_BITS'(pos_q) + SUM_BITS'(len_q)) > SUM_BITS'(WORD_MAX_LEN);
`ifdef WORD_EXTRACT_CHECK_EN
          state_d = StCmp;
`else
          state_d = StDone;
          empty_d = 1'b0;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef WORD_EXTRACT_CHECK_EN
      StCmp: begin
        mismatch_d = word_out_q != (ref_q & char_mask(len_q));
        state_d    = StDone;
        empty_d    = 1'b0;
      end
`endif
      StDone: begin
        if (bus.rd_en && !empty_q) begin
          empty_d = 1'b1;
          full_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= StIdle;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      din_q       <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      idx_q       <= '0;
      rc_q        <= '0;
      range_out_q <= '0;
      word_out_q  <= '0;
      range_len_q <= '0;
      zero_seen_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef WORD_EXTRACT_CHECK_EN
      ref_q       <= '0;
      mismatch_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      din_q       <= din_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      idx_q       <= idx_d;
      rc_q        <= rc_d;
      range_out_q <= range_out_d;
      word_out_q  <= word_out_d;
      range_len_q <= range_len_d;
      zero_seen_q <= zero_seen_d;
      err_q       <= err_d;
`ifdef WORD_EXTRACT_CHECK_EN
      ref_q       <= ref_d;
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.range_out = range_out_q;
  assign bus.range_len = range_len_q;
  assign bus.word_out  = word_out_q;
  assign bus.err       = err_q;
`ifdef WORD_EXTRACT_CHECK_EN
  assign bus.mismatch  = mismatch_q;
`else
  assign bus.mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_word_extract.sv
// Directed bench for word_extract: scoreboard of expected results, checked when empty falls.
module tb_word_extract;
  import word_extract_pkg::*;

  typedef struct {
    logic [RANGE_BITS-1:0]   range_out;
    logic [WORD_LEN_MSB:0]   range_len;
    logic [DATA_BITS-1:0]    word_out;
    logic                    err;
    logic                    mismatch;
  } exp_t;

`ifdef WORD_EXTRACT_CHECK_EN
  localparam int LATENCY = WORD_MAX_LEN + 2;
`else
  localparam int LATENCY = WORD_MAX_LEN + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  word_extract_if bus ();

  word_extract dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] cand(input string s);
    logic [DATA_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < int'(WORD_MAX_LEN); i++) v[i*CHAR_BITS +: CHAR_BITS] = s[i][6:0];
    return v;
  endfunction

  // Reference behaviour: walk chars, route each to word or range side.
  function automatic exp_t model(input logic [DATA_BITS-1:0] d, input int pos, input int len,
                                 input logic [DATA_BITS-1:0] r);
    exp_t e;
    int   rc;
    bit   zs;
    logic [CHAR_BITS-1:0] ch;
    logic [DATA_BITS-1:0] masked;
    e.range_out = '0; e.range_len = '0; e.word_out = '0; e.err = 1'b0; e.mismatch = 1'b0;
    rc = 0; zs = 0; masked = '0;
    for (int i = 0; i < int'(WORD_MAX_LEN); i++) begin
      ch = d[i*CHAR_BITS +: CHAR_BITS];
      if (i < len) masked[i*CHAR_BITS +: CHAR_BITS] = r[i*CHAR_BITS +: CHAR_BITS];
      if (i >= pos && i < pos + len) begin
        e.word_out[(i-pos)*CHAR_BITS +: CHAR_BITS] = ch;
      end else begin
        if (rc < int'(RANGES_MAX)) e.range_out[rc*CHAR_BITS +: CHAR_BITS] = ch;
        rc++;
        if (!zs) begin
          if (ch == 0) zs = 1;
          else e.range_len = e.range_len + 1'b1;
        end
      end
    end
    e.err = (pos + len) > int'(WORD_MAX_LEN);
`ifdef WORD_EXTRACT_CHECK_EN
    e.mismatch = (e.word_out != masked);
`endif
    return e;
  endfunction

  task automatic drive(input logic [DATA_BITS-1:0] d, input int pos, input int len,
                       input logic [DATA_BITS-1:0] r);
    bus.din      = d;
    bus.word_pos = POS_BITS'(pos);
    bus.word_len = (WORD_LEN_MSB+1)'(len);
    bus.word_ref = r;
  endtask

  // One accepted write; the expected result enters the scoreboard at the same time.
  task automatic write(input logic [DATA_BITS-1:0] d, input int pos, input int len,
                       input logic [DATA_BITS-1:0] r);
    drive(d, pos, len, r);
    bus.wr_en = 1'b1;
    sb.push_back(model(d, pos, len, r));
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (bus.empty && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LATENCY));
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_range_out"}, 64'(bus.range_out), 64'(e.range_out));
      check({tag, "_range_len"}, 64'(bus.range_len), 64'(e.range_len));
      check({tag, "_word_out"},  64'(bus.word_out),  64'(e.word_out));
      check({tag, "_err"},       64'(bus.err),       64'(e.err));
      check({tag, "_mismatch"},  64'(bus.mismatch),  64'(e.mismatch));
    end
  endtask

  task automatic read(input string tag);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_empty_after_rd"}, 64'(bus.empty), 64'd1);
    check({tag, "_full_after_rd"},  64'(bus.full),  64'd0);
  endtask

  initial begin
    logic [DATA_BITS-1:0] xyz;
    xyz = cand("XYZ");
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    drive('0, 0, 0, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_full",      64'(bus.full),      64'd0);
    check("rst_empty",     64'(bus.empty),     64'd1);
    check("rst_range_out", 64'(bus.range_out), 64'd0);
    check("rst_word_out",  64'(bus.word_out),  64'd0);
    check("rst_range_len", 64'(bus.range_len), 64'd0);
    check("rst_err",       64'(bus.err),       64'd0);
    check("rst_mismatch",  64'(bus.mismatch),  64'd0);

    // 1: mid-word insertion, direct constants as well as the model
    write(cand("abXYZc"), 2, 3, xyz);
    check("t1_full", 64'(bus.full), 64'd1);
    wait_result("t1");
    check("t1_const_range", 64'(bus.range_out), 64'(cand("abc")));
    check("t1_const_word",  64'(bus.word_out),  64'(xyz));
    check("t1_const_rlen",  64'(bus.range_len), 64'd3);
    check("t1_const_mis",   64'(bus.mismatch),  64'd0);
    compare_out("t1");
    read("t1");

    // 2: no word
    write(cand("hello"), 3, 0, '0);
    wait_result("t2");
    check("t2_const_range", 64'(bus.range_out), 64'(cand("hello")));
    check("t2_const_rlen",  64'(bus.range_len), 64'd5);
    compare_out("t2");
    read("t2");

    // 3: window overruns the candidate
    write(cand("ABCDEFGH"), 5, 4, cand("FGH"));
    wait_result("t3");
    check("t3_const_err",  64'(bus.err),      64'd1);
    check("t3_const_word", 64'(bus.word_out), 64'(cand("FGH")));
    check("t3_const_rng",  64'(bus.range_out), 64'(cand("ABCDE")));
    compare_out("t3");
    read("t3");

    // Whole candidate is the word
    write(cand("qrstuvwx"), 0, 8, cand("qrstuvwx"));
    wait_result("full_word");
    compare_out("full_word");
    read("full_word");

    // 4: wr_en held high; second candidate only enters after rd_en
    write(cand("mnOPq"), 2, 2, cand("OP"));
    drive(cand("zzKK"), 2, 2, cand("KK"));
    bus.wr_en = 1'b1;
    wait_result("t4a");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_full",  64'(bus.full),     64'd1);
      check("t4_hold_empty", 64'(bus.empty),    64'd0);
      check("t4_hold_word",  64'(bus.word_out), 64'(cand("OP")));
    end
    compare_out("t4a");
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t4_full_after_rd", 64'(bus.full), 64'd0);
    sb.push_back(model(cand("zzKK"), 2, 2, cand("KK")));
    tick();
    bus.wr_en = 1'b0;
    check("t4_second_accept", 64'(bus.full), 64'd1);
    wait_result("t4b");
    compare_out("t4b");
    read("t4b");

    // 5: reset while idx=3 is being scanned
    drive(cand("RESETME"), 1, 2, '0);
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_full",      64'(bus.full),      64'd0);
    check("t5_empty",     64'(bus.empty),     64'd1);
    check("t5_range_out", 64'(bus.range_out), 64'd0);
    check("t5_word_out",  64'(bus.word_out),  64'd0);
    check("t5_range_len", 64'(bus.range_len), 64'd0);
    write(cand("fresh1"), 1, 3, cand("res"));
    wait_result("t5");
    compare_out("t5");
    read("t5");

    // 6: word_ref differs in one char
    write(cand("abXYZc"), 2, 3, cand("XYQ"));
    wait_result("t6");
`ifdef WORD_EXTRACT_CHECK_EN
    check("t6_const_mis", 64'(bus.mismatch), 64'd1);
`else
    check("t6_const_mis", 64'(bus.mismatch), 64'd0);
`endif
    compare_out("t6");
    read("t6");

    // rd_en while empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rd_idle_empty", 64'(bus.empty), 64'd1);
    check("rd_idle_full",  64'(bus.full),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
